// File: rtl/uart_word_receive.sv
// Oversampled 8N1 UART receiver that packs BYTES frames into one word.
// Optional inter-byte gap abort when UART_RX_TIMEOUT_EN is defined.
module uart_word_receive #(
  parameter int UART_HZ      = 50000000,
  parameter int BAUDRATE     = 115200,
  parameter int DWIDTH       = 8,
  parameter int BYTES        = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_rx,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [BYTES*DWIDTH-1:0]   o_data,
  output logic                      o_frame_err,
  output logic                      o_timeout
);

  localparam int CPB = UART_HZ / BAUDRATE;
  localparam int TW  = $clog2(CPB + 1);
  localparam int BCW = $clog2(DWIDTH + 1);
  localparam int YW  = $clog2(BYTES + 1);
  localparam int W   = BYTES * DWIDTH;

  localparam logic [TW-1:0]  T_HALF    = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0]  T_BIT     = TW'(CPB - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DWIDTH - 1);
  localparam logic [YW-1:0]  LAST_BYTE = YW'(BYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic sync1_q, rx_s_q, rx_prev_q;
  logic fall, stop_tick, gap_hit;

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic [YW-1:0]     byte_q, byte_d;
  logic [DWIDTH-1:0] sh_q, sh_d;
  logic [W-1:0]      shadow_q, shadow_d;
  logic [W-1:0]      data_q, data_d;
  logic [W-1:0]      word;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= i_rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall      = rx_prev_q & ~rx_s_q;
  assign stop_tick = (state_q == S_STOP) && (tmr_q == T_BIT);

`ifdef UART_RX_TIMEOUT_EN
  localparam int GAP = TIMEOUT_BITS * CPB;
  localparam int GW  = $clog2(GAP + 1);

  logic [GW-1:0] gap_q, gap_d;
  logic          tout_q;

  // Gap counts cycles since the last accepted stop sample.
  always_comb begin
    gap_d   = '0;
    gap_hit = 1'b0;
    if (state_q == S_IDLE && byte_q != '0 && !fall) begin
      if (gap_q + GW'(1) == GW'(GAP)) gap_hit = 1'b1;
      else gap_d = gap_q + GW'(1);
    end else if (stop_tick && rx_s_q && byte_q != LAST_BYTE) begin
      gap_d = GW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      gap_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      gap_q  <= gap_d;
      tout_q <= gap_hit;
    end
  end

  assign o_timeout = tout_q;
`else
  logic [31:0] unused_to;
  assign unused_to = TIMEOUT_BITS;
  assign gap_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + TW'(1);
    bit_d    = bit_q;
    byte_d   = byte_q;
    sh_d     = sh_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    word     = shadow_q;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (fall) begin
          state_d = S_START;
          busy_d  = 1'b1;
        end else if (gap_hit) begin
          byte_d   = '0;
          shadow_d = '0;
          busy_d   = 1'b0;
        end
      end
      S_START: begin
        if (tmr_q == T_HALF) begin
          tmr_d = '0;
          bit_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
          end else begin
            state_d  = S_IDLE;
            ferr_d   = 1'b1;
            byte_d   = '0;
            shadow_d = '0;
            busy_d   = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (tmr_q == T_BIT) begin
          tmr_d = '0;
          sh_d  = {rx_s_q, sh_q[DWIDTH-1:1]};
          if (bit_q == LAST_BIT) state_d = S_STOP;
          else bit_d = bit_q + BCW'(1);
        end
      end
      default: begin
        if (stop_tick) begin
          tmr_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            word[byte_q*DWIDTH +: DWIDTH] = sh_q;
            if (byte_q == LAST_BYTE) begin
              data_d   = word;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              byte_d   = '0;
              shadow_d = '0;
            end else begin
              shadow_d = word;
              byte_d   = byte_q + YW'(1);
            end
          end else begin
            ferr_d   = 1'b1;
            byte_d   = '0;
            shadow_d = '0;
            busy_d   = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      sh_q     <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sh_q     <= sh_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_data      = data_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_word_receive.sv
// Randomized bench for uart_word_receive with a word-level reference model.
// Uses a small bit period (17 clocks) to keep runs short.
module tb_uart_word_receive;

  localparam int HZ   = 1700;
  localparam int BAUD = 100;
  localparam int CPB  = HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int DW   = 8;
  localparam int NB   = 8;
  localparam int TOB  = 20;
  localparam int TO   = TOB * CPB;
  localparam int W    = DW * NB;
  localparam time PER = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx;
  logic         o_busy, o_done, o_frame_err, o_timeout;
  logic [W-1:0] o_data;

  int errors = 0;
  int checks = 0;

  uart_word_receive #(
    .UART_HZ(HZ), .BAUDRATE(BAUD), .DWIDTH(DW),
    .BYTES(NB), .TIMEOUT_BITS(TOB)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_rx(rx),
    .o_busy(o_busy), .o_done(o_done), .o_data(o_data),
    .o_frame_err(o_frame_err), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int           done_cnt = 0;
  int           ferr_cnt = 0;
  int           tout_cnt = 0;
  int           busy_hi  = 0;
  bit           track_busy = 0;
  time          tout_t = 0;
  time          done_t[$];
  logic [W-1:0] done_w[$];

  always @(negedge clk) begin
    if (o_done) begin
      done_cnt++;
      done_t.push_back($time);
      done_w.push_back(o_data);
    end
    if (o_frame_err) ferr_cnt++;
    if (o_timeout) begin
      tout_cnt++;
      tout_t = $time;
    end
    if (track_busy && o_busy) busy_hi++;
  end

  // Frame start -> pulse time: 2 sync cycles, half bit, 9 bits, 1 register stage.
  function automatic time done_time(input time te);
    return te + 2*PER + (HALF + 9*CPB + 1)*PER + 5;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            output time te);
    te = $time;
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < DW; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clk);
    if (!stop) begin
      #1 rx = 1'b1;
      repeat (CPB) @(posedge clk);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, output time te_last);
    for (int k = 0; k < NB; k++) send_frame(w[8*k +: 8], 1'b1, te_last);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", o_busy);
    end
    checks++;
    if (o_done !== 1'b0 || o_frame_err !== 1'b0 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b%b%b want 000",
               o_done, o_frame_err, o_timeout);
    end
    checks++;
    if (o_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", o_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_full_word();
    logic [W-1:0] w = 64'h0123456789ABCDEF;
    time te;
    int c0 = done_cnt;
    int f0 = ferr_cnt;
    busy_hi = 0;
    track_busy = 1;
    send_word(w, te);
    repeat (20) @(posedge clk);
    track_busy = 0;
    checks++;
    if (done_cnt != c0 + 1) begin
      errors++;
      $display("FAIL full_done_count: got %0d want 1", done_cnt - c0);
    end
    checks++;
    if (done_w.size() == 0 || done_w[$] !== w) begin
      errors++;
      $display("FAIL full_data: got %h want %h", o_data, w);
    end
    checks++;
    if (done_t.size() == 0 || done_t[$] != done_time(te)) begin
      errors++;
      $display("FAIL full_done_time: got %0t want %0t",
               done_t.size() ? done_t[$] : 0, done_time(te));
    end
    checks++;
    if (busy_hi != 79*CPB + HALF) begin
      errors++;
      $display("FAIL full_busy_len: got %0d want %0d", busy_hi, 79*CPB + HALF);
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL full_no_ferr: got %0d want 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] d0 = o_data;
    int c0 = done_cnt;
    int f0 = ferr_cnt;
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ferr_cnt != f0 + 1) begin
      errors++;
      $display("FAIL glitch_ferr: got %0d want 1", ferr_cnt - f0);
    end
    checks++;
    if (done_cnt != c0) begin
      errors++;
      $display("FAIL glitch_no_done: got %0d want 0", done_cnt - c0);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got %b want 0", o_busy);
    end
    checks++;
    if (o_data !== d0) begin
      errors++;
      $display("FAIL glitch_data: got %h want %h", o_data, d0);
    end
    @(posedge clk);
  endtask

  task automatic test_framing();
    logic [W-1:0] d0 = o_data;
    logic [W-1:0] w = 64'h8877665544332211;
    time te;
    int c0 = done_cnt;
    int f0 = ferr_cnt;
    for (int k = 0; k < 3; k++) send_frame(8'($urandom), 1'b1, te);
    send_frame(8'($urandom), 1'b0, te);
    @(negedge clk);
    checks++;
    if (ferr_cnt != f0 + 1) begin
      errors++;
      $display("FAIL frame_ferr: got %0d want 1", ferr_cnt - f0);
    end
    checks++;
    if (o_busy !== 1'b0 || o_data !== d0 || done_cnt != c0) begin
      errors++;
      $display("FAIL frame_abort: busy %b data %h done %0d want 0 %h 0",
               o_busy, o_data, done_cnt - c0, d0);
    end
    @(posedge clk);
    send_word(w, te);
    repeat (10) @(posedge clk);
    checks++;
    if (done_cnt != c0 + 1 || done_w[$] !== w) begin
      errors++;
      $display("FAIL frame_recover: got %h want %h", o_data, w);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b[3];
    time te;
    int t0 = tout_cnt;
    int c0 = done_cnt;
    logic [W-1:0] w;
    for (int k = 0; k < 3; k++) begin
      b[k] = 8'($urandom);
      send_frame(b[k], 1'b1, te);
    end
    repeat (25*CPB) @(posedge clk);
    @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
    checks++;
    if (tout_cnt != t0 + 1) begin
      errors++;
      $display("FAIL tout_count: got %0d want 1", tout_cnt - t0);
    end
    checks++;
    if (tout_t != te + 2*PER + (HALF + 9*CPB + TO)*PER + 5) begin
      errors++;
      $display("FAIL tout_time: got %0t want %0t", tout_t,
               te + 2*PER + (HALF + 9*CPB + TO)*PER + 5);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL tout_busy: got %b want 0", o_busy);
    end
    @(posedge clk);
    w = rand_word();
    send_word(w, te);
`else
    checks++;
    if (tout_cnt != t0) begin
      errors++;
      $display("FAIL tout_none: got %0d want 0", tout_cnt - t0);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL tout_wait_busy: got %b want 1", o_busy);
    end
    @(posedge clk);
    w = rand_word();
    w[23:0] = {b[2], b[1], b[0]};
    for (int k = 3; k < NB; k++) send_frame(w[8*k +: 8], 1'b1, te);
`endif
    repeat (10) @(posedge clk);
    checks++;
    if (done_cnt != c0 + 1 || done_w[$] !== w) begin
      errors++;
      $display("FAIL tout_word: got %h want %h", o_data, w);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    time te;
    int c0 = done_cnt;
    int f0 = ferr_cnt;
    for (int k = 0; k < 4; k++) send_frame(8'($urandom), 1'b1, te);
    #1 rx = 1'b0;
    repeat (3*CPB) @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_frame_err !== 1'b0 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags: got %b%b%b%b want 0000",
               o_busy, o_done, o_frame_err, o_timeout);
    end
    checks++;
    if (o_data !== '0) begin
      errors++;
      $display("FAIL rstmid_data: got %h want 0", o_data);
    end
    repeat (5) @(posedge clk);
    w = rand_word();
    send_word(w, te);
    repeat (10) @(posedge clk);
    checks++;
    if (done_cnt != c0 + 1 || done_w[$] !== w) begin
      errors++;
      $display("FAIL rstmid_word: got %h want %h", o_data, w);
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL rstmid_ferr: got %0d want 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1 = rand_word();
    logic [W-1:0] w2 = rand_word();
    time te1, te2;
    int c0 = done_cnt;
    send_word(w1, te1);
    send_word(w2, te2);
    repeat (10) @(posedge clk);
    checks++;
    if (done_cnt != c0 + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", done_cnt - c0);
    end else begin
      checks++;
      if (done_w[c0] !== w1 || done_w[c0+1] !== w2) begin
        errors++;
        $display("FAIL b2b_data: got %h %h want %h %h",
                 done_w[c0], done_w[c0+1], w1, w2);
      end
      checks++;
      if (done_t[c0+1] - done_t[c0] != time'(80*CPB)*PER) begin
        errors++;
        $display("FAIL b2b_spacing: got %0t want %0t",
                 done_t[c0+1] - done_t[c0], time'(80*CPB)*PER);
      end
      checks++;
      if (done_t[c0] != done_time(te1)) begin
        errors++;
        $display("FAIL b2b_time: got %0t want %0t", done_t[c0], done_time(te1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_glitch();
    test_framing();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
